regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter REGISTERS_NUMBER, default 32, number of architectural registers.
REQ-003 SHALL have parameter ADDR_BUS_WIDTH, default 5, register address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, synchronous and active-low.
REQ-006 SHALL have ports alu_valid_i, alu_addr_i, alu_data_i  input  1/ADDR_BUS_WIDTH/DATA_WIDTH  ALU writeback request, destination register, result.
REQ-007 SHALL have port alu_ready_o  output  1  ALU request accepted this cycle.
REQ-008 SHALL have ports lsu_valid_i, lsu_addr_i, lsu_data_i  input  1/ADDR_BUS_WIDTH/DATA_WIDTH  load-unit writeback request, destination register, load data.
REQ-009 SHALL have port lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-010 SHALL have ports issue_en_i, issue_addr_i  input  1/ADDR_BUS_WIDTH  an instruction with destination issue_addr_i issues this cycle.
REQ-011 SHALL have ports rf_write_en_o, rf_write_addr_o, rf_write_data_o  output  1/ADDR_BUS_WIDTH/DATA_WIDTH  registered register-file write port.
REQ-012 SHALL have port busy_o  output  REGISTERS_NUMBER  scoreboard; bit n set = write to register n pending.
REQ-013 SHALL have port conflict_o  output  1  sticky flag: writeback committed to a register not marked busy.

Function
REQ-014 Arbitration SHALL be round-robin over two requesters via a 1-bit last_grant register (0=ALU, 1=LSU).
REQ-015 Only one valid: that requester granted (ready_o=1) the same cycle, combinationally from valid_i and last_grant.
REQ-016 Both valid: grant to the requester not equal to last_grant; other ready_o=0 and must hold its request.
REQ-017 last_grant SHALL update only on a granted handshake (valid & ready); idle cycles leave it unchanged.
REQ-018 Accepted handshake SHALL produce rf_write_en_o=1, rf_write_addr_o/rf_write_data_o = granted addr/data on the next cycle (latency 1); otherwise rf_write_en_o=0 next cycle.
REQ-019 Throughput SHALL be one write per cycle; no bubble between back-to-back grants.
REQ-020 Address 0 request: accepted (ready_o=1), no rf_write_en_o pulse, no scoreboard/conflict effect.
REQ-021 issue_en_i=1, issue_addr_i!=0: busy_o[issue_addr_i] SHALL be set at the next edge.
REQ-022 Accepted handshake with addr!=0: busy_o[addr] SHALL clear at the same edge rf_write_en_o rises.
REQ-023 Issue and accepted writeback to the same register in the same cycle: set SHALL win (busy stays 1).
REQ-024 Accepted handshake to addr!=0 with busy_o[addr]=0 that cycle: write still forwarded; conflict_o set next edge, held until reset.
REQ-025 busy_o[0] SHALL be constant 0.
REQ-026 rf_write_addr_o/rf_write_data_o SHALL hold previous values when rf_write_en_o=0.

Reset
REQ-027 reset_i=0 at a rising edge SHALL force: rf_write_en_o=0, rf_write_addr_o=0, rf_write_data_o=0, busy_o=0, conflict_o=0, last_grant=1 (first contention goes to ALU).
REQ-028 alu_ready_o/lsu_ready_o SHALL be 0 while reset_i=0; requests during reset are not accepted.
REQ-029 Reset mid-operation SHALL discard any write registered for the next cycle; no rf_write_en_o pulse after reset release unless a new handshake occurs.

Verification
REQ-030 Issue x5, then ALU valid addr 5 data 0xDEADBEEF -> alu_ready_o=1; next cycle rf_write_en_o=1, addr 5, data 0xDEADBEEF, busy_o[5]=0, conflict_o=0.
REQ-031 After reset, ALU (addr 3, 0x11) and LSU (addr 4, 0x22) valid for 3 cycles -> grants ALU, LSU, ALU; writes 3/0x11, 4/0x22, 3/0x11 on consecutive cycles.
REQ-032 LSU valid addr 0 data 0xFFFFFFFF -> lsu_ready_o=1, rf_write_en_o stays 0, busy_o and conflict_o unchanged.
REQ-033 busy_o[7]=1; same cycle issue x7 and ALU writeback addr 7 -> write forwarded next cycle, busy_o[7] remains 1.
REQ-034 ALU writeback addr 9 with busy_o[9]=0 -> write forwarded, conflict_o=1 and stays 1 until reset_i=0.
REQ-035 ALU handshake accepted, reset_i=0 on following edge -> rf_write_en_o=0, busy_o=0 after that edge; no write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU/LSU) round-robin writeback arbiter in front of the register file,
// with a per-register pending-write scoreboard and a sticky unexpected-writeback flag.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REGISTERS_NUMBER = 32,
  parameter int unsigned ADDR_BUS_WIDTH   = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        alu_valid_i,
  input  logic [ADDR_BUS_WIDTH-1:0]   alu_addr_i,
  input  logic [DATA_WIDTH-1:0]       alu_data_i,
  output logic                        alu_ready_o,
  input  logic                        lsu_valid_i,
  input  logic [ADDR_BUS_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]       lsu_data_i,
  output logic                        lsu_ready_o,
  input  logic                        issue_en_i,
  input  logic [ADDR_BUS_WIDTH-1:0]   issue_addr_i,
  output logic                        rf_write_en_o,
  output logic [ADDR_BUS_WIDTH-1:0]   rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]       rf_write_data_o,
  output logic [REGISTERS_NUMBER-1:0] busy_o,
  output logic                        conflict_o
);

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  logic                        last_grant;
  logic [REGISTERS_NUMBER-1:0] busy_q;
  logic [REGISTERS_NUMBER-1:0] busy_nxt_c;
  logic                        alu_grant_c;
  logic                        lsu_grant_c;
  logic                        wb_fire_c;
  logic                        wb_live_c;
  logic                        wb_busy_c;
  logic [ADDR_BUS_WIDTH-1:0]   wb_addr_c;
  logic [DATA_WIDTH-1:0]       wb_data_c;

  // Round-robin grant: on contention the requester that did not win last goes next.
  always_comb begin
    alu_grant_c = 1'b0;
    lsu_grant_c = 1'b0;
    if (reset_i) begin
      if (alu_valid_i && lsu_valid_i) begin
        alu_grant_c = (last_grant == GRANT_LSU);
        lsu_grant_c = (last_grant == GRANT_ALU);
      end else begin
        alu_grant_c = alu_valid_i;
        lsu_grant_c = lsu_valid_i;
      end
    end
  end

  assign alu_ready_o = alu_grant_c;
  assign lsu_ready_o = lsu_grant_c;

  assign wb_fire_c = alu_grant_c | lsu_grant_c;
  assign wb_addr_c = lsu_grant_c ? lsu_addr_i : alu_addr_i;
  assign wb_data_c = lsu_grant_c ? lsu_data_i : alu_data_i;
  // Register 0 is hardwired: accepted but never written or tracked.
  assign wb_live_c = wb_fire_c && (wb_addr_c != '0);

  // Scoreboard next state: writeback clears, issue sets, and set wins on a collision.
  always_comb begin
    busy_nxt_c = busy_q;
    wb_busy_c  = 1'b0;
    for (int unsigned i = 1; i < REGISTERS_NUMBER; i++) begin
      if (wb_addr_c == ADDR_BUS_WIDTH'(i)) begin
        wb_busy_c = wb_busy_c | busy_q[i];
        if (wb_live_c) begin
          busy_nxt_c[i] = 1'b0;
        end
      end
      if (issue_en_i && (issue_addr_i == ADDR_BUS_WIDTH'(i))) begin
        busy_nxt_c[i] = 1'b1;
      end
    end
    busy_nxt_c[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      last_grant      <= GRANT_LSU;
      rf_write_en_o   <= 1'b0;
      rf_write_addr_o <= '0;
      rf_write_data_o <= '0;
      busy_q          <= '0;
      conflict_o      <= 1'b0;
    end else begin
      if (wb_fire_c) begin
        last_grant <= lsu_grant_c ? GRANT_LSU : GRANT_ALU;
      end
      rf_write_en_o <= wb_live_c;
      if (wb_live_c) begin
        rf_write_addr_o <= wb_addr_c;
        rf_write_data_o <= wb_data_c;
      end
      busy_q <= busy_nxt_c;
      if (wb_live_c && !wb_busy_c) begin
        conflict_o <= 1'b1;
      end
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a transaction-level model.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alu_valid_i, lsu_valid_i, issue_en_i;
  logic [4:0]  alu_addr_i, lsu_addr_i, issue_addr_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic        alu_ready_o, lsu_ready_o, rf_write_en_o, conflict_o;
  logic [4:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;
  logic [31:0] busy_o;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .REGISTERS_NUMBER(32), .ADDR_BUS_WIDTH(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .issue_en_i(issue_en_i), .issue_addr_i(issue_addr_i),
    .rf_write_en_o(rf_write_en_o), .rf_write_addr_o(rf_write_addr_o),
    .rf_write_data_o(rf_write_data_o), .busy_o(busy_o), .conflict_o(conflict_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference state: who won last, which registers await a write, expected write port.
  int          m_last;       // 0 = ALU, 1 = LSU
  logic [31:0] m_busy;
  logic        m_conflict;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        got_alu, got_lsu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (!reset_i) return -1;
    if (alu_valid_i && lsu_valid_i) return (m_last == 1) ? 0 : 1;
    if (alu_valid_i) return 0;
    if (lsu_valid_i) return 1;
    return -1;
  endfunction

  task automatic drive(input logic rst,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic ie, input logic [4:0] ia);
    reset_i = rst;
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
    issue_en_i = ie; issue_addr_i = ia;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // One clock: check grants before the edge, advance the model, check registered outputs after.
  task automatic cycle();
    int w;
    logic [4:0] a;
    logic [31:0] d;
    #1;
    w = winner();
    check("alu_ready", 64'(alu_ready_o), 64'(w == 0));
    check("lsu_ready", 64'(lsu_ready_o), 64'(w == 1));
    got_alu = alu_ready_o;
    got_lsu = lsu_ready_o;
    @(posedge clk_i);
    if (!reset_i) begin
      m_last = 1; m_busy = '0; m_conflict = 1'b0;
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_en = 1'b0;
      if (w >= 0) begin
        a = (w == 0) ? alu_addr_i : lsu_addr_i;
        d = (w == 0) ? alu_data_i : lsu_data_i;
        m_last = w;
        if (a != 0) begin
          m_en = 1'b1; m_addr = a; m_data = d;
          if (!m_busy[a]) m_conflict = 1'b1;
          m_busy[a] = 1'b0;
        end
      end
      if (issue_en_i && issue_addr_i != 0) m_busy[issue_addr_i] = 1'b1;
    end
    #1;
    check("wr_en", 64'(rf_write_en_o), 64'(m_en));
    check("wr_addr", 64'(rf_write_addr_o), 64'(m_addr));
    check("wr_data", 64'(rf_write_data_o), 64'(m_data));
    check("busy", 64'(busy_o), 64'(m_busy));
    check("conflict", 64'(conflict_o), 64'(m_conflict));
    @(negedge clk_i);
  endtask

  initial begin
    m_last = 1; m_busy = '0; m_conflict = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0;
    got_alu = 1'b0; got_lsu = 1'b0;

    // Reset with a pending request: nothing may be accepted.
    drive(1'b0, 1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66, 1'b1, 5'd6);
    cycle(); cycle();
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_en", 64'(rf_write_en_o), 64'd0);

    // Issue x5, then ALU writes 5.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    cycle();
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle();
    check("basic_ready", 64'(got_alu), 64'd1);
    check("basic_data", 64'(rf_write_data_o), 64'hDEADBEEF);
    check("basic_busy5", 64'(busy_o[5]), 64'd0);
    check("basic_conflict", 64'(conflict_o), 64'd0);

    // Contention right after reset: ALU, LSU, ALU.
    idle(1'b0); cycle();
    drive(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    cycle();
    check("rr0_alu", 64'(got_alu), 64'd1);
    check("rr0_addr", 64'(rf_write_addr_o), 64'd3);
    cycle();
    check("rr1_lsu", 64'(got_lsu), 64'd1);
    check("rr1_data", 64'(rf_write_data_o), 64'h22);
    cycle();
    check("rr2_alu", 64'(got_alu), 64'd1);
    check("rr2_data", 64'(rf_write_data_o), 64'h11);

    // Address-0 write is accepted but invisible.
    idle(1'b0); cycle();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
    cycle();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    cycle();
    check("zero_ready", 64'(got_lsu), 64'd1);
    check("zero_en", 64'(rf_write_en_o), 64'd0);
    check("zero_busy", 64'(busy_o), 64'h4);

    // Issue and writeback to 7 together: set wins.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cycle();
    drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cycle();
    check("setwin_en", 64'(rf_write_en_o), 64'd1);
    check("setwin_busy7", 64'(busy_o[7]), 64'd1);
    check("setwin_conflict", 64'(conflict_o), 64'd0);

    // Write to non-busy 9 raises a sticky conflict.
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle();
    check("conf_en", 64'(rf_write_en_o), 64'd1);
    check("conf_set", 64'(conflict_o), 64'd1);
    idle(1'b1); cycle(); cycle();
    check("conf_sticky", 64'(conflict_o), 64'd1);

    // Handshake followed immediately by reset: the registered write is dropped.
    drive(1'b1, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13);
    cycle();
    idle(1'b0); cycle();
    check("rst_mid_en", 64'(rf_write_en_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_conf", 64'(conflict_o), 64'd0);
    idle(1'b1); cycle(); cycle();
    check("rst_release_en", 64'(rf_write_en_o), 64'd0);

    // Random traffic, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(39) != 0),
            1'($urandom), 5'($urandom_range(31)), $urandom,
            1'($urandom), 5'($urandom_range(31)), $urandom,
            1'($urandom), 5'($urandom_range(31)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
